// File: rtl/credit_flow_control_nport_pkg.sv
// rtl/credit_flow_control_nport_pkg.sv - shared port encodings and defaults for the credit flow control
package credit_flow_control_nport_pkg;

    localparam int SW_X1    = 0;
    localparam int SW_X2    = 1;
    localparam int SW_Y1    = 2;
    localparam int SW_LOCAL = 3;

    localparam logic [2:0] SW_NONE = 3'b111;

    localparam int DEFAULT_CREDIT_DEPTH = 4;

endpackage

// File: rtl/credit_flow_control_nport_credit_counter.sv
// rtl/credit_flow_control_nport_credit_counter.sv - per-output saturating credit counter with sticky overflow flag
module credit_counter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= FULL;
            err <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    // A return into a full counter means the downstream over-reported space
                    if (cnt == FULL) err <= 1'b1;
                    else             cnt <= cnt + 1'b1;
                end
                2'b01: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/credit_flow_control_nport.sv
// rtl/credit_flow_control_nport.sv - credit-based pop gating with multicast and per-input stall watchdog
module credit_flow_control_nport
    import credit_flow_control_nport_pkg::*;
#(
    parameter int NUM_PORTS    = 4,
    parameter int SEL_W        = 3,
    parameter int CREDIT_DEPTH = DEFAULT_CREDIT_DEPTH,
    parameter int STALL_LIMIT  = 255,
    localparam int CNT_W       = $clog2(CREDIT_DEPTH + 1),
    localparam int STL_W       = $clog2(STALL_LIMIT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PORTS*SEL_W-1:0] out_sw,
    input  logic [NUM_PORTS-1:0]       valid_in,
    input  logic [NUM_PORTS-1:0]       empty_in,
    input  logic [NUM_PORTS-1:0]       credit_in,
    output logic [NUM_PORTS-1:0]       en_in,
    output logic [NUM_PORTS-1:0]       en_fifo,
    output logic [NUM_PORTS-1:0]       send_out,
    output logic [NUM_PORTS*CNT_W-1:0] credit_cnt,
    output logic [NUM_PORTS-1:0]       credit_err,
    output logic [NUM_PORTS-1:0]       stall_alarm
);

    logic [NUM_PORTS-1:0] conn [NUM_PORTS];
    logic [CNT_W-1:0]     cnt  [NUM_PORTS];
    logic [STL_W-1:0]     stall_cnt [NUM_PORTS];
    logic [NUM_PORTS-1:0] ready;
    logic [NUM_PORTS-1:0] blocked;

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            conn[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                conn[o][i] = (32'(out_sw[o*SEL_W +: SEL_W]) == i) &&
                             (32'(out_sw[o*SEL_W +: SEL_W]) < NUM_PORTS);
            end
        end
    end

    // Multicast is all-or-none: every connected output must hold a credit
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            logic any_conn;
            logic all_credit;
            any_conn   = 1'b0;
            all_credit = 1'b1;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (conn[o][i]) begin
                    any_conn = 1'b1;
                    if (cnt[o] == '0) all_credit = 1'b0;
                end
            end
            ready[i] = any_conn & all_credit;
        end
    end

    always_comb begin
        en_in   = ~valid_in | ready;
        en_fifo = en_in & ~empty_in;
        blocked = valid_in & ~en_in;
        for (int o = 0; o < NUM_PORTS; o++) begin
            send_out[o] = |(conn[o] & valid_in & ready);
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_credit
        credit_counter #(
            .DEPTH (CREDIT_DEPTH),
            .CNT_W (CNT_W)
        ) u_credit_counter (
            .clk (clk),
            .rst (rst),
            .dec (send_out[o]),
            .inc (credit_in[o]),
            .cnt (cnt[o]),
            .err (credit_err[o])
        );
        assign credit_cnt[o*CNT_W +: CNT_W] = cnt[o];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rst || !blocked[i]) begin
                stall_cnt[i] <= '0;
            end else if (stall_cnt[i] != STL_W'(STALL_LIMIT)) begin
                stall_cnt[i] <= stall_cnt[i] + 1'b1;
            end
        end
    end

    // Counter saturates at the limit, so the alarm is a registered value
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            stall_alarm[i] = (stall_cnt[i] == STL_W'(STALL_LIMIT));
        end
    end

endmodule

// File: tb/tb_credit_flow_control_nport.sv
// tb/tb_credit_flow_control_nport.sv - scoreboard bench for credit_flow_control_nport
module tb_credit_flow_control_nport;
    import credit_flow_control_nport_pkg::*;

    localparam int NP = 4;
    localparam int SW = 3;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NP*SW-1:0] out_sw;
    logic [NP-1:0]   valid_in, empty_in, credit_in;
    logic [NP-1:0]   en_in, en_fifo, send_out, credit_err, stall_alarm;
    logic [NP*CW-1:0] credit_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    credit_flow_control_nport #(
        .NUM_PORTS    (NP),
        .SEL_W        (SW),
        .CREDIT_DEPTH (4),
        .STALL_LIMIT  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .out_sw      (out_sw),
        .valid_in    (valid_in),
        .empty_in    (empty_in),
        .credit_in   (credit_in),
        .en_in       (en_in),
        .en_fifo     (en_fifo),
        .send_out    (send_out),
        .credit_cnt  (credit_cnt),
        .credit_err  (credit_err),
        .stall_alarm (stall_alarm)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t x;
        x.tag = tag;
        x.val = v;
        sbq.push_back(x);
    endtask

    function automatic logic [2:0] cnt_of(input int o);
        return credit_cnt[o*CW +: CW];
    endfunction

    function automatic logic [NP*SW-1:0] sw_all_none();
        logic [NP*SW-1:0] v;
        for (int o = 0; o < NP; o++) v[o*SW +: SW] = SW_NONE;
        return v;
    endfunction

    task automatic do_reset;
        rst       = 1'b1;
        out_sw    = sw_all_none();
        valid_in  = '0;
        empty_in  = '0;
        credit_in = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        push("reset_cnt", 32'h924);
        push("reset_err", 32'h0);
        push("reset_alarm", 32'h0);
        push("reset_en_in", 32'hf);
        push("reset_send", 32'h0);
        @(negedge clk);
        e = sbq.pop_front(); n_cmp++;
        if (credit_cnt !== e.val[11:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, credit_cnt, e.val[11:0]); end
        e = sbq.pop_front(); n_cmp++;
        if (credit_err !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, credit_err, e.val[3:0]); end
        e = sbq.pop_front(); n_cmp++;
        if (stall_alarm !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, stall_alarm, e.val[3:0]); end
        e = sbq.pop_front(); n_cmp++;
        if (en_in !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, en_in, e.val[3:0]); end
        e = sbq.pop_front(); n_cmp++;
        if (send_out !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, send_out, e.val[3:0]); end
    endtask

    task automatic test_credit_drain;
        do_reset();
        out_sw[1*SW +: SW] = 3'd0;
        valid_in = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            push($sformatf("drain_send%0d", k), 32'b0010);
            push($sformatf("drain_cnt%0d", k), 32'(3 - k));
            @(negedge clk);
            e = sbq.pop_front(); n_cmp++;
            if (send_out !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, send_out, e.val[3:0]); end
            tick();
            e = sbq.pop_front(); n_cmp++;
            if (cnt_of(1) !== e.val[2:0]) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.tag, cnt_of(1), e.val[2:0]); end
        end
        push("drain_en_in", 32'b1110);
        push("drain_en_fifo", 32'b1110);
        push("drain_nosend", 32'h0);
        @(negedge clk);
        e = sbq.pop_front(); n_cmp++;
        if (en_in !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, en_in, e.val[3:0]); end
        e = sbq.pop_front(); n_cmp++;
        if (en_fifo !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, en_fifo, e.val[3:0]); end
        e = sbq.pop_front(); n_cmp++;
        if (send_out !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, send_out, e.val[3:0]); end
    endtask

    task automatic test_send_and_return;
        valid_in  = '0;
        credit_in = 4'b0010;
        tick();
        tick();
        push("sr_cnt_two", 32'd2);
        e = sbq.pop_front(); n_cmp++;
        if (cnt_of(1) !== e.val[2:0]) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.tag, cnt_of(1), e.val[2:0]); end
        valid_in = 4'b0001;
        push("sr_send", 32'b0010);
        push("sr_cnt_same", 32'd2);
        @(negedge clk);
        e = sbq.pop_front(); n_cmp++;
        if (send_out !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, send_out, e.val[3:0]); end
        tick();
        e = sbq.pop_front(); n_cmp++;
        if (cnt_of(1) !== e.val[2:0]) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.tag, cnt_of(1), e.val[2:0]); end
        valid_in = '0;
        push("sr_cnt_ret", 32'd3);
        tick();
        e = sbq.pop_front(); n_cmp++;
        if (cnt_of(1) !== e.val[2:0]) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.tag, cnt_of(1), e.val[2:0]); end
        credit_in = '0;
    endtask

    task automatic test_multicast;
        do_reset();
        out_sw[2*SW +: SW] = 3'd1;
        valid_in = 4'b0010;
        for (int k = 0; k < 4; k++) tick();
        out_sw[3*SW +: SW] = 3'd1;
        push("mc_cnt2_empty", 32'd0);
        push("mc_blocked_en", 32'b1101);
        push("mc_nosend", 32'h0);
        e = sbq.pop_front(); n_cmp++;
        if (cnt_of(2) !== e.val[2:0]) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.tag, cnt_of(2), e.val[2:0]); end
        @(negedge clk);
        e = sbq.pop_front(); n_cmp++;
        if (en_in !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, en_in, e.val[3:0]); end
        e = sbq.pop_front(); n_cmp++;
        if (send_out !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, send_out, e.val[3:0]); end
        credit_in = 4'b0100;
        tick();
        credit_in = '0;
        push("mc_send_both", 32'b1100);
        push("mc_cnt2_after", 32'd0);
        push("mc_cnt3_after", 32'd3);
        @(negedge clk);
        e = sbq.pop_front(); n_cmp++;
        if (send_out !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, send_out, e.val[3:0]); end
        tick();
        valid_in = '0;
        e = sbq.pop_front(); n_cmp++;
        if (cnt_of(2) !== e.val[2:0]) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.tag, cnt_of(2), e.val[2:0]); end
        e = sbq.pop_front(); n_cmp++;
        if (cnt_of(3) !== e.val[2:0]) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.tag, cnt_of(3), e.val[2:0]); end
    endtask

    task automatic test_overflow;
        do_reset();
        credit_in = 4'b0001;
        tick();
        credit_in = '0;
        push("ovf_cnt_sat", 32'd4);
        push("ovf_err_set", 32'b0001);
        e = sbq.pop_front(); n_cmp++;
        if (cnt_of(0) !== e.val[2:0]) begin n_bad++; $display("FAIL %s: got %0d want %0d", e.tag, cnt_of(0), e.val[2:0]); end
        e = sbq.pop_front(); n_cmp++;
        if (credit_err !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, credit_err, e.val[3:0]); end
        for (int k = 0; k < 3; k++) tick();
        push("ovf_err_sticky", 32'b0001);
        e = sbq.pop_front(); n_cmp++;
        if (credit_err !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, credit_err, e.val[3:0]); end
        do_reset();
        push("ovf_err_clr", 32'b0000);
        e = sbq.pop_front(); n_cmp++;
        if (credit_err !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, credit_err, e.val[3:0]); end
    endtask

    task automatic test_watchdog;
        do_reset();
        valid_in = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k >= 7) begin
                push($sformatf("wd_alarm_after%0d", k), (k >= 8) ? 32'b0100 : 32'b0000);
                e = sbq.pop_front(); n_cmp++;
                if (stall_alarm !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, stall_alarm, e.val[3:0]); end
            end
        end
        out_sw[0*SW +: SW] = 3'(SW_Y1);
        push("wd_release_send", 32'b0001);
        push("wd_alarm_held", 32'b0100);
        push("wd_alarm_drop", 32'b0000);
        @(negedge clk);
        e = sbq.pop_front(); n_cmp++;
        if (send_out !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, send_out, e.val[3:0]); end
        e = sbq.pop_front(); n_cmp++;
        if (stall_alarm !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, stall_alarm, e.val[3:0]); end
        tick();
        e = sbq.pop_front(); n_cmp++;
        if (stall_alarm !== e.val[3:0]) begin n_bad++; $display("FAIL %s: got %h want %h", e.tag, stall_alarm, e.val[3:0]); end
        valid_in = '0;
    endtask

    initial begin
        rst       = 1'b1;
        out_sw    = sw_all_none();
        valid_in  = '0;
        empty_in  = '0;
        credit_in = '0;
        test_reset();
        test_credit_drain();
        test_send_and_return();
        test_multicast();
        test_overflow();
        test_watchdog();
        n_cmp++;
        if (sbq.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
